// File: rtl/breakout_pkg.sv
// Shared breakout definitions: game_state encodings seen by the mover and the
// VGA picture block, plus brick and score sizing.
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_LOSE = 2'b10,
    ST_WIN  = 2'b11
  } game_state_e;

  localparam int BRICK_COUNT = 50;
  localparam int BRICKS_W    = 6;
  localparam int SCORE_W     = 12;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    CTRL_IDLE,
    CTRL_SERVE,
    CTRL_PLAY,
    CTRL_OVER,
    CTRL_WIN
  } ctrl_state_e;

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-FF synchroniser, stability counter and
// a single-cycle pulse on each accepted press (stable 1->0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Only a released->pressed change produces a pulse.
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press_q  <= stable_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: serve/play/over/win flow, lives, score and brick
// accounting, driving the shared game_state and game_reset lines.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int SERVE_DELAY      = 12500000,
  parameter int LIVES_INIT       = 3,
  parameter int POINTS_PER_BRICK = 10
) (
  input  logic                   vga_clk,
  input  logic                   sys_rst_n,
  input  logic                   start_key,
  input  logic                   lose_sig,
  input  logic [BRICK_COUNT-1:0] brick_collision,
  output logic [1:0]             game_state,
  output logic                   game_reset,
  output logic [1:0]             lives,
  output logic [SCORE_W-1:0]     score,
  output logic [BRICKS_W-1:0]    bricks_cleared
);

  localparam int SERVE_W = $clog2(SERVE_DELAY + 1);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_DELAY - 1);
  localparam int SUM_W = SCORE_W + 8;

  function automatic logic [BRICKS_W-1:0] popcount(input logic [BRICK_COUNT-1:0] v);
    logic [BRICKS_W-1:0] c;
    c = '0;
    for (int i = 0; i < BRICK_COUNT; i++) begin
      c = c + BRICKS_W'(v[i]);
    end
    return c;
  endfunction

  logic start_pulse;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_key (
    .clk_i  (vga_clk),
    .rst_ni (sys_rst_n),
    .key_i  (start_key),
    .press_o(start_pulse)
  );

  ctrl_state_e            state_q;
  game_state_e            game_state_q;
  logic                   game_reset_q;
  logic [1:0]             lives_q;
  logic [SCORE_W-1:0]     score_q;
  logic [BRICKS_W-1:0]    bricks_q;
  logic [SERVE_W-1:0]     serve_cnt_q;
  logic [BRICK_COUNT-1:0] collision_q;

  logic [BRICKS_W-1:0] hit_count;
  logic [BRICKS_W:0]   bricks_sum;
  logic [SUM_W-1:0]    score_sum;
  logic [BRICKS_W-1:0] bricks_d;
  logic [SCORE_W-1:0]  score_d;
  logic                win_now;

  // A hit counts once, on the cycle its collision bit rises.
  always_comb begin
    hit_count  = popcount(brick_collision & ~collision_q);
    bricks_sum = {1'b0, bricks_q} + {1'b0, hit_count};
    score_sum  = SUM_W'(score_q) + SUM_W'(hit_count) * SUM_W'(POINTS_PER_BRICK);
    win_now    = bricks_sum >= (BRICKS_W + 1)'(BRICK_COUNT);
    bricks_d   = win_now ? BRICKS_W'(BRICK_COUNT) : bricks_sum[BRICKS_W-1:0];
    score_d    = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      collision_q <= '0;
    end else begin
      collision_q <= brick_collision;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= CTRL_IDLE;
      game_state_q <= ST_IDLE;
      game_reset_q <= 1'b1;
      lives_q      <= 2'(LIVES_INIT);
      score_q      <= '0;
      bricks_q     <= '0;
      serve_cnt_q  <= '0;
    end else begin
      case (state_q)
        CTRL_IDLE: begin
          if (start_pulse) begin
            state_q      <= CTRL_SERVE;
            game_state_q <= ST_PLAY;
            lives_q      <= 2'(LIVES_INIT);
            score_q      <= '0;
            bricks_q     <= '0;
            serve_cnt_q  <= '0;
          end
        end
        CTRL_SERVE: begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_q      <= CTRL_PLAY;
            game_reset_q <= 1'b0;
          end else begin
            serve_cnt_q <= serve_cnt_q + SERVE_W'(1);
          end
        end
        CTRL_PLAY: begin
          score_q  <= score_d;
          bricks_q <= bricks_d;
          // Clearing the last brick beats a simultaneous loss.
          if (win_now) begin
            state_q      <= CTRL_WIN;
            game_state_q <= ST_WIN;
            game_reset_q <= 1'b1;
          end else if (lose_sig) begin
            game_reset_q <= 1'b1;
            if (lives_q <= 2'd1) begin
              state_q      <= CTRL_OVER;
              game_state_q <= ST_LOSE;
              lives_q      <= 2'd0;
            end else begin
              state_q     <= CTRL_SERVE;
              lives_q     <= lives_q - 2'd1;
              serve_cnt_q <= '0;
            end
          end
        end
        CTRL_OVER, CTRL_WIN: begin
          if (start_pulse) begin
            state_q      <= CTRL_IDLE;
            game_state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= CTRL_IDLE;
          game_state_q <= ST_IDLE;
          game_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign game_state     = game_state_q;
  assign game_reset     = game_reset_q;
  assign lives          = lives_q;
  assign score          = score_q;
  assign bricks_cleared = bricks_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: directed game scenarios plus random play,
// compared every cycle against a behavioural game model.
module tb_breakout_game_ctrl;

  localparam int DEB   = 4;
  localparam int SD    = 8;
  localparam int LIVES = 3;
  localparam int PTS   = 10;
  localparam int NB    = 50;
  localparam int SMAX  = 4095;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_OVER  = 3;
  localparam int P_WIN   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_key = 1'b1;
  logic          lose_sig = 1'b0;
  logic [NB-1:0] bc = '0;
  logic [1:0]    game_state;
  logic          game_reset;
  logic [1:0]    lives;
  logic [11:0]   score;
  logic [5:0]    bricks_cleared;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  int            m_phase, m_lives, m_score, m_bricks, m_serve_left, m_run;
  bit            m_stable, m_pulse;
  bit            key_hist[$];
  logic [NB-1:0] m_prev;

  always #5 clk = ~clk;

  breakout_game_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .SERVE_DELAY     (SD),
    .LIVES_INIT      (LIVES),
    .POINTS_PER_BRICK(PTS)
  ) dut (
    .vga_clk        (clk),
    .sys_rst_n      (rst_n),
    .start_key      (start_key),
    .lose_sig       (lose_sig),
    .brick_collision(bc),
    .game_state     (game_state),
    .game_reset     (game_reset),
    .lives          (lives),
    .score          (score),
    .bricks_cleared (bricks_cleared)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    m_phase = P_IDLE; m_lives = LIVES; m_score = 0; m_bricks = 0;
    m_serve_left = 0; m_run = 0; m_stable = 1'b1; m_pulse = 1'b0;
    m_prev = '0;
    key_hist.delete();
    key_hist.push_back(1'b1);
    key_hist.push_back(1'b1);
  endtask

  task automatic model_step();
    logic [NB-1:0] fresh;
    int n;
    bit synced, pulse_next;
    fresh = bc & ~m_prev;
    n = $countones(fresh);
    m_prev = bc;
    case (m_phase)
      P_IDLE: if (m_pulse) begin
        m_phase = P_SERVE; m_lives = LIVES; m_score = 0; m_bricks = 0; m_serve_left = SD;
      end
      P_SERVE: begin
        m_serve_left--;
        if (m_serve_left == 0) m_phase = P_PLAY;
      end
      P_PLAY: begin
        m_bricks = (m_bricks + n > NB) ? NB : m_bricks + n;
        m_score  = (m_score + n * PTS > SMAX) ? SMAX : m_score + n * PTS;
        if (m_bricks >= NB) m_phase = P_WIN;
        else if (lose_sig) begin
          if (m_lives == 1) begin m_phase = P_OVER; m_lives = 0; end
          else begin m_lives--; m_phase = P_SERVE; m_serve_left = SD; end
        end
      end
      default: if (m_pulse) m_phase = P_IDLE;
    endcase
    // Key level seen two clocks late; accepted after DEB consecutive disagreeing samples.
    synced = key_hist.pop_front();
    key_hist.push_back(start_key);
    pulse_next = 1'b0;
    if (synced != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        pulse_next = m_stable;
        m_stable = synced;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_pulse = pulse_next;
  endtask

  function automatic int exp_gs();
    case (m_phase)
      P_IDLE:  return 0;
      P_OVER:  return 2;
      P_WIN:   return 3;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("game_state", int'(game_state), exp_gs());
      chk("game_reset", int'(game_reset), int'(m_phase != P_PLAY));
      chk("lives", int'(lives), m_lives);
      chk("score", int'(score), m_score);
      chk("bricks_cleared", int'(bricks_cleared), m_bricks);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input int n);
    start_key = 1'b0;
    repeat (n) tick();
    start_key = 1'b1;
    repeat (8) tick();
  endtask

  task automatic wait_phase(input int p, input int budget, input string what);
    for (int i = 0; i < budget; i++) begin
      if (m_phase == p) return;
      tick();
    end
    if (m_phase != p) begin
      n_checks++;
      $display("FAIL timeout_%s: model phase %0d required %0d", what, m_phase, p);
    end
  endtask

  initial begin
    int key_left;
    int lose_left;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(game_state), 0);
    chk("rst_game_reset", int'(game_reset), 1);
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Short glitch must not start a game.
    start_key = 1'b0;
    repeat (2) tick();
    start_key = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("glitch_idle", int'(game_state), 0);

    // Proper press: serve, then play.
    start_key = 1'b0;
    wait_phase(P_SERVE, 20, "serve1");
    @(negedge clk);
    chk("serve_state", int'(game_state), 1);
    chk("serve_reset", int'(game_reset), 1);
    repeat (3) tick();
    start_key = 1'b1;
    wait_phase(P_PLAY, 30, "play1");
    @(negedge clk);
    chk("play_reset", int'(game_reset), 0);
    chk("play_lives", int'(lives), 3);

    // Held brick counts once; two simultaneous rises both count.
    bc[7] = 1'b1;
    tick();
    @(negedge clk);
    chk("hit1_bricks", int'(bricks_cleared), 1);
    chk("hit1_score", int'(score), 10);
    repeat (19) tick();
    bc[3] = 1'b1;
    bc[40] = 1'b1;
    tick();
    @(negedge clk);
    chk("hit2_bricks", int'(bricks_cleared), 3);
    chk("hit2_score", int'(score), 30);
    bc = '0;
    tick();

    // Three losses; the last one arrives with lose_sig already high at play entry.
    lose_sig = 1'b1;
    tick();
    lose_sig = 1'b0;
    @(negedge clk);
    chk("lose1_lives", int'(lives), 2);
    wait_phase(P_PLAY, 20, "play2");
    lose_sig = 1'b1;
    tick();
    lose_sig = 1'b0;
    @(negedge clk);
    chk("lose2_lives", int'(lives), 1);
    lose_sig = 1'b1;
    wait_phase(P_OVER, 20, "over");
    lose_sig = 1'b0;
    @(negedge clk);
    chk("over_state", int'(game_state), 2);
    chk("over_lives", int'(lives), 0);
    chk("over_reset", int'(game_reset), 1);

    // Back to idle keeps the final score visible; then a fresh game to win.
    press(10);
    wait_phase(P_IDLE, 10, "idle1");
    @(negedge clk);
    chk("idle_score_kept", int'(score), 30);
    press(10);
    wait_phase(P_PLAY, 40, "play3");
    for (int i = 0; i < NB; i++) begin
      bc[i] = 1'b1;
      if (i == NB - 1) lose_sig = 1'b1;
      tick();
    end
    lose_sig = 1'b0;
    @(negedge clk);
    chk("win_state", int'(game_state), 3);
    chk("win_bricks", int'(bricks_cleared), 50);
    chk("win_score", int'(score), 500);
    chk("win_lives", int'(lives), 3);
    bc = '0;

    // Reset in the middle of play.
    press(10);
    press(10);
    wait_phase(P_PLAY, 40, "play4");
    bc[5] = 1'b1;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", int'(game_state), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_lives", int'(lives), 3);
    tick();
    rst_n = 1'b1;
    bc = '0;
    press(10);
    wait_phase(P_PLAY, 40, "play5");
    @(negedge clk);
    chk("fresh_state", int'(game_state), 1);
    chk("fresh_reset", int'(game_reset), 0);

    // Random play.
    key_left = 0;
    lose_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (key_left > 0) begin
        start_key = 1'b0;
        key_left--;
      end else begin
        start_key = 1'b1;
        if ($urandom_range(0, 59) == 0) key_left = $urandom_range(1, 12);
      end
      if (lose_left > 0) begin
        lose_sig = 1'b1;
        lose_left--;
      end else begin
        lose_sig = 1'b0;
        if ($urandom_range(0, 49) == 0) lose_left = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 2) == 0) begin
        int b;
        b = $urandom_range(0, NB - 1);
        bc[b] = ~bc[b];
      end
      if ($urandom_range(0, 99) == 0) bc = NB'({$urandom(), $urandom()});
      rst_n = ($urandom_range(0, 1499) != 0);
      tick();
    end
    rst_n = 1'b1;
    start_key = 1'b1;
    lose_sig = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
